// File: rtl/writeback_arbiter.sv
// Merges the in-order pipe writeback with a FIFO of async results into one register-file write port.
// Registered write one cycle after selection; async input backpressured only when the FIFO is full.
module writeback_arbiter #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               pipe_valid,
  input  logic [DEPTH-1:0]                   pipe_index,
  input  logic [WIDTH-1:0]                   pipe_data,
  input  logic                               async_valid,
  output logic                               async_ready,
  input  logic [DEPTH-1:0]                   async_index,
  input  logic [WIDTH-1:0]                   async_data,
  output logic                               stall_request,
  output logic [(2**DEPTH)-1:0]              pending_mask,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               write_enable,
  output logic [DEPTH-1:0]                   write_index,
  output logic [WIDTH-1:0]                   write_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  logic [DEPTH-1:0] idx_mem  [FIFO_DEPTH];
  logic [WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [ST_W-1:0]  starve_cnt;
  logic [PTR_W-1:0] age [FIFO_DEPTH];

  logic pipe_occupies;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;

  assign pipe_occupies = pipe_valid && (pipe_index != '0);
  assign fifo_empty    = (count == '0);
  assign fifo_full     = (count == CNT_W'(FIFO_DEPTH));
  // Readiness ignores a same-cycle pop: a full FIFO never refills in the cycle it drains.
  assign async_ready   = reset && !fifo_full;
  // Index-0 results complete the handshake but are never buffered.
  assign push          = async_valid && async_ready && (async_index != '0);
  assign pop           = !pipe_occupies && !fifo_empty;
  assign fifo_count    = count;
  assign stall_request = (starve_cnt == ST_W'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[wr_ptr]  <= async_index;
      data_mem[wr_ptr] <= async_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (fifo_empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != ST_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + ST_W'(1);
    end
  end

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      age[i] = PTR_W'(i) - rd_ptr;
      if (CNT_W'(age[i]) < count) pending_mask[idx_mem[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      write_enable <= 1'b0;
      write_index  <= '0;
      write_data   <= '0;
    end else if (pipe_occupies) begin
      write_enable <= 1'b1;
      write_index  <= pipe_index;
      write_data   <= pipe_data;
    end else if (!fifo_empty) begin
      write_enable <= 1'b1;
      write_index  <= idx_mem[rd_ptr];
      write_data   <= data_mem[rd_ptr];
    end else begin
      write_enable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter with a queue-based reference model and write scoreboard.
module tb_writeback_arbiter;

  localparam int FD = 4;
  localparam int SL = 8;

  logic        clk;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_index;
  logic [31:0] pipe_data;
  logic        async_valid;
  logic        async_ready;
  logic [4:0]  async_index;
  logic [31:0] async_data;
  logic        stall_request;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;
  logic        write_enable;
  logic [4:0]  write_index;
  logic [31:0] write_data;

  writeback_arbiter #(.WIDTH(32), .DEPTH(5), .FIFO_DEPTH(FD), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_index(pipe_index), .pipe_data(pipe_data),
    .async_valid(async_valid), .async_ready(async_ready),
    .async_index(async_index), .async_data(async_data),
    .stall_request(stall_request), .pending_mask(pending_mask), .fifo_count(fifo_count),
    .write_enable(write_enable), .write_index(write_index), .write_data(write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct { logic [4:0] idx; logic [31:0] dat; } ent_t;
  typedef struct { int cyc; logic [4:0] idx; logic [31:0] dat; } wr_t;

  ent_t        mq[$];
  wr_t         exp_q[$];
  int          starve = 0;
  logic        hold_we = 1'b0;
  logic [4:0]  hold_idx = '0;
  logic [31:0] hold_dat = '0;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) m[mq[i].idx] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic check_state();
    chk("async_ready", 64'(async_ready), 64'(reset && (mq.size() < FD)));
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    chk("pending_mask", 64'(pending_mask), 64'(model_mask()));
    chk("stall_request", 64'(stall_request), 64'(starve == SL));
    chk("write_enable", 64'(write_enable), 64'(hold_we));
    chk("write_index_hold", 64'(write_index), 64'(hold_idx));
    chk("write_data_hold", 64'(write_data), 64'(hold_dat));
  endtask

  task automatic model_step();
    int   sz;
    bit   popped;
    ent_t h;
    sz = mq.size();
    popped = 0;
    if (!reset) begin
      mq.delete();
      starve   = 0;
      hold_we  = 1'b0;
      hold_idx = '0;
      hold_dat = '0;
    end else begin
      if (pipe_valid && pipe_index != 0) begin
        exp_q.push_back('{cycle + 1, pipe_index, pipe_data});
        hold_we = 1'b1; hold_idx = pipe_index; hold_dat = pipe_data;
      end else if (sz > 0) begin
        h = mq.pop_front();
        popped = 1;
        exp_q.push_back('{cycle + 1, h.idx, h.dat});
        hold_we = 1'b1; hold_idx = h.idx; hold_dat = h.dat;
      end else begin
        hold_we = 1'b0;
      end
      if (sz == 0 || popped) starve = 0;
      else if (starve < SL) starve++;
      if (async_valid && sz < FD && async_index != 0) mq.push_back('{async_index, async_data});
    end
  endtask

  task automatic cyc(input logic rst, input logic pv, input logic [4:0] pi, input logic [31:0] pd,
                     input logic av, input logic [4:0] ai, input logic [31:0] ad);
    reset = rst; pipe_valid = pv; pipe_index = pi; pipe_data = pd;
    async_valid = av; async_index = ai; async_data = ad;
    @(negedge clk);
    check_state();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Write monitor: every register-file write must match the oldest expected write, in the expected cycle.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (write_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_write: got idx %0d data %0h, expected no write (cycle %0d)",
                   write_index, write_data, cycle);
        end else begin
          e = exp_q.pop_front();
          chk("wr_cycle", 64'(cycle), 64'(e.cyc));
          chk("wr_index", 64'(write_index), 64'(e.idx));
          chk("wr_data", 64'(write_data), 64'(e.dat));
        end
      end
    end
  end

  initial begin
    logic        pv;
    logic        av;
    logic        rst;
    reset = 1'b0; pipe_valid = 1'b0; pipe_index = '0; pipe_data = '0;
    async_valid = 1'b1; async_index = 5'd4; async_data = 32'h1;
    @(posedge clk);
    #1;
    // Reset held with async_valid high, then released.
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h1);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h1);
    idle(2);
    // Single pipe write, then an index-0 pipe result that must be dropped.
    cyc(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    cyc(1'b1, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0);
    idle(3);
    // Back-to-back async pushes with the pipe idle.
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA7A7A7A7);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hB9B9B9B9);
    idle(4);
    // Starvation: pipe hogs the slot while five async results are offered.
    for (int k = 0; k < 14; k++)
      cyc(1'b1, 1'b1, 5'd3, 32'h300 + k, (k < 5), 5'(10 + k), 32'hC000 + k);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'hF00D);
    idle(6);
    // Fill / drain rounds exercise pointer wrap.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < FD; k++)
        cyc(1'b1, 1'b1, 5'd2, 32'h200 + k, 1'b1, 5'(11 + 4 * r + k), 32'(r * 16 + k));
      idle(6);
    end
    // Reset with three buffered entries: none may ever be written.
    for (int k = 0; k < 3; k++)
      cyc(1'b1, 1'b1, 5'd6, 32'h600 + k, 1'b1, 5'(21 + k), 32'hE000 + k);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    idle(6);
    // Random traffic, mostly honouring stall_request, with rare resets.
    for (int k = 0; k < 3000; k++) begin
      if (stall_request && ($urandom_range(0, 3) != 0)) pv = ($urandom_range(0, 7) == 0);
      else pv = ($urandom_range(0, 2) != 0);
      av  = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 199) != 0);
      cyc(rst, pv, 5'($urandom_range(0, 31)), $urandom, av, 5'($urandom_range(0, 31)), $urandom);
    end
    idle(FD + 4);
    chk("missing_writes", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
